// File: rtl/sirv_tl_fragmenter_a.sv
// Splits multi-byte TileLink A requests into single-byte beats for an 8-bit port
// and folds the per-byte D responses back into one response per original request.
module sirv_tl_fragmenter_a #(
  parameter int MAX_SIZE = 6
) (
  input  logic        clock,
  input  logic        rst_n,

  output logic        io_repeat,

  output logic        io_in_a_ready,
  input  logic        io_in_a_valid,
  input  logic [2:0]  io_in_a_opcode,
  input  logic [2:0]  io_in_a_param,
  input  logic [2:0]  io_in_a_size,
  input  logic [1:0]  io_in_a_source,
  input  logic [29:0] io_in_a_address,
  input  logic        io_in_a_mask,
  input  logic [7:0]  io_in_a_data,

  input  logic        io_out_a_ready,
  output logic        io_out_a_valid,
  output logic [2:0]  io_out_a_opcode,
  output logic [2:0]  io_out_a_param,
  output logic [2:0]  io_out_a_size,
  output logic [2:0]  io_out_a_source,
  output logic [29:0] io_out_a_address,
  output logic        io_out_a_mask,
  output logic [7:0]  io_out_a_data,

  output logic        io_out_d_ready,
  input  logic        io_out_d_valid,
  input  logic [2:0]  io_out_d_opcode,
  input  logic [1:0]  io_out_d_param,
  input  logic [2:0]  io_out_d_size,
  input  logic [2:0]  io_out_d_source,
  input  logic        io_out_d_sink,
  input  logic [7:0]  io_out_d_data,
  input  logic        io_out_d_error,

  input  logic        io_in_d_ready,
  output logic        io_in_d_valid,
  output logic [2:0]  io_in_d_opcode,
  output logic [1:0]  io_in_d_param,
  output logic [2:0]  io_in_d_size,
  output logic [1:0]  io_in_d_source,
  output logic        io_in_d_sink,
  output logic [7:0]  io_in_d_data,
  output logic        io_in_d_error
);

  logic [MAX_SIZE-1:0] cnt;
  logic [MAX_SIZE-1:0] lim;
  logic [2:0]          size_tab [4];
  logic [3:0]          err_sticky;

  logic is_get;
  logic is_pass;
  logic last;
  logic a_fire;

  logic [1:0] d_src;
  logic       d_lb;
  logic       drop;
  logic       d_fire;

  // The slave's response size is per-byte; the master sees the recorded size instead.
  logic unused_d_size;
  assign unused_d_size = ^io_out_d_size;

  // ---------------- A channel ----------------
  assign is_get  = (io_in_a_opcode == 3'd4);
  assign is_pass = (io_in_a_opcode >= 3'd5);

  // Shifted all-ones mask equals (1<<size)-1 truncated; oversize requests saturate to all ones.
  assign lim  = ~({MAX_SIZE{1'b1}} << io_in_a_size);
  assign last = is_pass | (cnt == lim);

  assign a_fire    = io_out_a_valid & io_out_a_ready;
  assign io_repeat = io_in_a_valid & is_get & ~last;

  assign io_out_a_valid   = io_in_a_valid;
  assign io_in_a_ready    = io_out_a_ready;
  assign io_out_a_opcode  = io_in_a_opcode;
  assign io_out_a_param   = io_in_a_param;
  assign io_out_a_size    = is_pass ? io_in_a_size : 3'd0;
  assign io_out_a_source  = {last, io_in_a_source};
  assign io_out_a_address = io_in_a_address | {{(30-MAX_SIZE){1'b0}}, cnt};
  assign io_out_a_mask    = is_get ? 1'b1 : io_in_a_mask;
  assign io_out_a_data    = io_in_a_data;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (a_fire) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + {{(MAX_SIZE-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) size_tab[i] <= 3'd0;
    end else if (a_fire && (cnt == '0)) begin
      size_tab[io_in_a_source] <= io_in_a_size;
    end
  end

  // ---------------- D channel ----------------
  assign d_src = io_out_d_source[1:0];
  assign d_lb  = io_out_d_source[2];

  // Acks for non-final Put fragments are swallowed; their errors are remembered.
  assign drop   = (io_out_d_opcode == 3'd0) & ~d_lb;
  assign d_fire = io_out_d_valid & io_out_d_ready;

  assign io_out_d_ready = drop ? 1'b1 : io_in_d_ready;
  assign io_in_d_valid  = io_out_d_valid & ~drop;
  assign io_in_d_opcode = io_out_d_opcode;
  assign io_in_d_param  = io_out_d_param;
  assign io_in_d_size   = size_tab[d_src];
  assign io_in_d_source = d_src;
  assign io_in_d_sink   = io_out_d_sink;
  assign io_in_d_data   = io_out_d_data;
  assign io_in_d_error  = io_out_d_error | err_sticky[d_src];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 4'd0;
    end else if (d_fire) begin
      if (drop) begin
        if (io_out_d_error) err_sticky[d_src] <= 1'b1;
      end else if (d_lb) begin
        err_sticky[d_src] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sirv_tl_fragmenter_a.sv
// Self-checking bench for sirv_tl_fragmenter_a: directed scenarios plus random
// transactions compared against a transaction-level expectation of each beat.
module tb_sirv_tl_fragmenter_a;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_repeat;
  logic        io_in_a_ready;
  logic        io_in_a_valid = 1'b0;
  logic [2:0]  io_in_a_opcode = '0;
  logic [2:0]  io_in_a_param = '0;
  logic [2:0]  io_in_a_size = '0;
  logic [1:0]  io_in_a_source = '0;
  logic [29:0] io_in_a_address = '0;
  logic        io_in_a_mask = 1'b0;
  logic [7:0]  io_in_a_data = '0;
  logic        io_out_a_ready = 1'b0;
  logic        io_out_a_valid;
  logic [2:0]  io_out_a_opcode;
  logic [2:0]  io_out_a_param;
  logic [2:0]  io_out_a_size;
  logic [2:0]  io_out_a_source;
  logic [29:0] io_out_a_address;
  logic        io_out_a_mask;
  logic [7:0]  io_out_a_data;
  logic        io_out_d_ready;
  logic        io_out_d_valid = 1'b0;
  logic [2:0]  io_out_d_opcode = '0;
  logic [1:0]  io_out_d_param = '0;
  logic [2:0]  io_out_d_size = '0;
  logic [2:0]  io_out_d_source = '0;
  logic        io_out_d_sink = 1'b0;
  logic [7:0]  io_out_d_data = '0;
  logic        io_out_d_error = 1'b0;
  logic        io_in_d_ready = 1'b0;
  logic        io_in_d_valid;
  logic [2:0]  io_in_d_opcode;
  logic [1:0]  io_in_d_param;
  logic [2:0]  io_in_d_size;
  logic [1:0]  io_in_d_source;
  logic        io_in_d_sink;
  logic [7:0]  io_in_d_data;
  logic        io_in_d_error;

  int n_checks = 0;
  int n_errors = 0;
  // Errors of swallowed Put acks per source, owed to the final response.
  logic [3:0] owed_err = 4'd0;

  sirv_tl_fragmenter_a #(.MAX_SIZE(6)) dut (
    .clock(clock), .rst_n(rst_n), .io_repeat(io_repeat),
    .io_in_a_ready(io_in_a_ready), .io_in_a_valid(io_in_a_valid),
    .io_in_a_opcode(io_in_a_opcode), .io_in_a_param(io_in_a_param),
    .io_in_a_size(io_in_a_size), .io_in_a_source(io_in_a_source),
    .io_in_a_address(io_in_a_address), .io_in_a_mask(io_in_a_mask),
    .io_in_a_data(io_in_a_data),
    .io_out_a_ready(io_out_a_ready), .io_out_a_valid(io_out_a_valid),
    .io_out_a_opcode(io_out_a_opcode), .io_out_a_param(io_out_a_param),
    .io_out_a_size(io_out_a_size), .io_out_a_source(io_out_a_source),
    .io_out_a_address(io_out_a_address), .io_out_a_mask(io_out_a_mask),
    .io_out_a_data(io_out_a_data),
    .io_out_d_ready(io_out_d_ready), .io_out_d_valid(io_out_d_valid),
    .io_out_d_opcode(io_out_d_opcode), .io_out_d_param(io_out_d_param),
    .io_out_d_size(io_out_d_size), .io_out_d_source(io_out_d_source),
    .io_out_d_sink(io_out_d_sink), .io_out_d_data(io_out_d_data),
    .io_out_d_error(io_out_d_error),
    .io_in_d_ready(io_in_d_ready), .io_in_d_valid(io_in_d_valid),
    .io_in_d_opcode(io_in_d_opcode), .io_in_d_param(io_in_d_param),
    .io_in_d_size(io_in_d_size), .io_in_d_source(io_in_d_source),
    .io_in_d_sink(io_in_d_sink), .io_in_d_data(io_in_d_data),
    .io_in_d_error(io_in_d_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plays the repeater plus master: presents one request until every byte has gone out.
  // stall < 0: random out_a_ready; stall >= 0: that many stalled cycles before each fire.
  task automatic do_a(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                      input logic [29:0] addr, input logic [7:0] dbase,
                      input int stall, input int stop_after);
    int n, i, waited, guard;
    logic exp_last;
    n = (op >= 3'd5) ? 1 : (1 << size);
    i = 0; waited = 0; guard = 0;
    while (i < n && i != stop_after) begin
      @(negedge clock);
      io_in_a_valid   = 1'b1;
      io_in_a_opcode  = op;
      io_in_a_param   = 3'($urandom);
      io_in_a_size    = size;
      io_in_a_source  = src;
      io_in_a_address = addr;
      io_in_a_mask    = (op == 3'd4) ? 1'b0 : 1'($urandom);
      io_in_a_data    = (op < 3'd4) ? 8'(dbase + i) : 8'($urandom);
      io_out_a_ready  = (stall < 0) ? ($urandom_range(0, 3) != 0) : (waited == stall);
      #1;
      exp_last = (op >= 3'd5) || (i == n - 1);
      check("a_valid",  io_out_a_valid, 1);
      check("a_ready",  io_in_a_ready, io_out_a_ready);
      check("a_opcode", io_out_a_opcode, op);
      check("a_param",  io_out_a_param, io_in_a_param);
      check("a_addr",   io_out_a_address, 32'(addr) + 32'(i));
      check("a_size",   io_out_a_size, (op >= 3'd5) ? size : 3'd0);
      check("a_source", io_out_a_source, {exp_last, src});
      check("a_repeat", io_repeat, (op == 3'd4) && !exp_last);
      check("a_mask",   io_out_a_mask, (op == 3'd4) ? 1'b1 : io_in_a_mask);
      check("a_data",   io_out_a_data, (op < 3'd4) ? 8'(dbase + i) : io_in_a_data);
      if (io_out_a_ready) begin i++; waited = 0; end
      else waited++;
      guard++;
      if (guard > 5000) begin check("a_timeout", 0, 1); break; end
    end
    @(negedge clock);
    io_in_a_valid  = 1'b0;
    io_out_a_ready = 1'b0;
    #1;
    check("a_repeat_idle", io_repeat, 0);
  endtask

  // Plays the slave: one response per byte, error per byte taken from err_mask.
  task automatic do_d(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                      input logic [63:0] err_mask);
    int n, j, guard;
    logic [2:0] dop;
    logic lb, e;
    n = (op >= 3'd5) ? 1 : (1 << size);
    dop = (op <= 3'd1) ? 3'd0 : (op <= 3'd4) ? 3'd1 : 3'd2;
    j = 0; guard = 0;
    while (j < n) begin
      @(negedge clock);
      lb = (j == n - 1);
      e  = err_mask[j];
      io_out_d_valid  = 1'b1;
      io_out_d_opcode = dop;
      io_out_d_param  = 2'($urandom);
      io_out_d_size   = 3'($urandom);
      io_out_d_source = {lb, src};
      io_out_d_sink   = 1'($urandom);
      io_out_d_data   = 8'($urandom);
      io_out_d_error  = e;
      io_in_d_ready   = ($urandom_range(0, 3) != 0);
      #1;
      if (dop == 3'd0 && !lb) begin
        check("d_drop_valid", io_in_d_valid, 0);
        check("d_drop_ready", io_out_d_ready, 1);
        owed_err[src] = owed_err[src] | e;
        j++;
      end else begin
        check("d_valid",  io_in_d_valid, 1);
        check("d_ready",  io_out_d_ready, io_in_d_ready);
        check("d_opcode", io_in_d_opcode, dop);
        check("d_param",  io_in_d_param, io_out_d_param);
        check("d_source", io_in_d_source, src);
        check("d_size",   io_in_d_size, size);
        check("d_sink",   io_in_d_sink, io_out_d_sink);
        check("d_data",   io_in_d_data, io_out_d_data);
        check("d_error",  io_in_d_error, e | owed_err[src]);
        if (io_in_d_ready) begin
          if (lb) owed_err[src] = 1'b0;
          j++;
        end
      end
      guard++;
      if (guard > 5000) begin check("d_timeout", 0, 1); break; end
    end
    @(negedge clock);
    io_out_d_valid = 1'b0;
    io_in_d_ready  = 1'b0;
  endtask

  initial begin
    logic [2:0]  r_op, r_size;
    logic [1:0]  r_src;
    logic [29:0] r_addr;
    logic [63:0] r_err;

    // Reset state
    repeat (2) @(negedge clock);
    io_out_d_valid  = 1'b1;
    io_out_d_opcode = 3'd1;
    io_out_d_source = 3'b110;
    io_in_d_ready   = 1'b1;
    #1;
    check("rst_repeat", io_repeat, 0);
    check("rst_a_valid", io_out_a_valid, 0);
    check("rst_d_size", io_in_d_size, 0);
    check("rst_d_error", io_in_d_error, 0);
    @(negedge clock);
    io_out_d_valid = 1'b0;
    io_in_d_ready  = 1'b0;
    rst_n = 1'b1;

    // Get of 4 bytes
    do_a(3'd4, 3'd2, 2'd1, 30'h100, 8'h00, 0, -1);
    do_d(3'd4, 3'd2, 2'd1, 64'd0);

    // PutFull of 8 bytes, clean then with fragment 2 in error
    do_a(3'd0, 3'd3, 2'd1, 30'h40, 8'h00, 0, -1);
    do_d(3'd0, 3'd3, 2'd1, 64'd0);
    do_a(3'd0, 3'd3, 2'd1, 30'h40, 8'h00, 0, -1);
    do_d(3'd0, 3'd3, 2'd1, 64'h4);
    do_a(3'd0, 3'd0, 2'd1, 30'h48, 8'h5a, 0, -1);
    do_d(3'd0, 3'd0, 2'd1, 64'd0);

    // Backpressure: three stalled cycles before each fragment
    do_a(3'd4, 3'd1, 2'd2, 30'h80, 8'h00, 3, -1);
    do_d(3'd4, 3'd1, 2'd2, 64'd0);

    // Reset after 2 of 4 Get fragments
    do_a(3'd4, 3'd2, 2'd3, 30'h200, 8'h00, 0, 2);
    @(negedge clock);
    rst_n = 1'b0;
    owed_err = 4'd0;
    io_in_a_valid   = 1'b1;
    io_in_a_opcode  = 3'd4;
    io_in_a_size    = 3'd2;
    io_in_a_source  = 2'd3;
    io_in_a_address = 30'h200;
    io_out_d_valid  = 1'b1;
    io_out_d_opcode = 3'd1;
    io_out_d_source = 3'b111;
    #1;
    check("rst_mid_addr", io_out_a_address, 30'h200);
    check("rst_mid_source", io_out_a_source, 3'b011);
    check("rst_mid_repeat", io_repeat, 1);
    check("rst_mid_d_size", io_in_d_size, 0);
    @(negedge clock);
    io_in_a_valid  = 1'b0;
    io_out_d_valid = 1'b0;
    rst_n = 1'b1;
    do_a(5'd5, 3'd2, 2'd3, 30'h300, 8'h00, 0, -1);
    do_d(3'd5, 3'd2, 2'd3, 64'd0);
    do_a(3'd4, 3'd2, 2'd3, 30'h200, 8'h00, 0, -1);
    do_d(3'd4, 3'd2, 2'd3, 64'd0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      r_op   = 3'($urandom_range(0, 5));
      r_size = 3'($urandom_range(0, 6));
      r_src  = 2'($urandom);
      r_addr = 30'($urandom);
      r_addr = (r_addr >> r_size) << r_size;
      r_err  = {$urandom, $urandom} & {$urandom, $urandom};
      do_a(r_op, r_size, r_src, r_addr, 8'($urandom), -1, -1);
      do_d(r_op, r_size, r_src, r_err);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sirv_tl_fragmenter_a.md
# sirv_tl_fragmenter_a

Splits multi-byte TileLink A-channel requests into single-byte requests for an 8-bit peripheral port, and folds the resulting D-channel responses back into what the master expects. It sits directly downstream of the per-port A-channel repeater. It consumes the repeater's dequeue side, and drives the repeater's `repeat` input so that a held Get is replayed once per byte. The block is combinational in the data path. Its state is a fragment counter, a per-source size table and per-source sticky error bits.

## Interface
- `MAX_SIZE`, default 6: largest accepted log2 transfer size (64 bytes). Counter width is `MAX_SIZE` bits.
- `clock` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_repeat` out 1: to the repeater; high means "keep this A message for another beat".
- `io_in_a_ready` out 1, `io_in_a_valid` in 1: from the repeater dequeue side.
- `io_in_a_opcode` in 3, `io_in_a_param` in 3, `io_in_a_size` in 3, `io_in_a_source` in 2, `io_in_a_address` in 30, `io_in_a_mask` in 1, `io_in_a_data` in 8.
- `io_out_a_ready` in 1, `io_out_a_valid` out 1.
- `io_out_a_opcode` out 3, `io_out_a_param` out 3, `io_out_a_size` out 3, `io_out_a_source` out 3, `io_out_a_address` out 30, `io_out_a_mask` out 1, `io_out_a_data` out 8.
- `io_out_d_ready` out 1, `io_out_d_valid` in 1, `io_out_d_opcode` in 3, `io_out_d_param` in 2, `io_out_d_size` in 3, `io_out_d_source` in 3, `io_out_d_sink` in 1, `io_out_d_data` in 8, `io_out_d_error` in 1: response channel from the slave.
- `io_in_d_ready` in 1, `io_in_d_valid` out 1, `io_in_d_opcode` out 3, `io_in_d_param` out 2, `io_in_d_size` out 3, `io_in_d_source` out 2, `io_in_d_sink` out 1, `io_in_d_data` out 8, `io_in_d_error` out 1: response channel to the master.

## Operation
- **Fragment counter.**
  - `cnt` is `MAX_SIZE` bits.
  - `lim = (1<<size)-1`, truncated to `MAX_SIZE` bits.
  - `last = (cnt == lim)`.
  - A fire is `io_out_a_valid & io_out_a_ready`. On a fire: if `last`, `cnt` is set to 0; otherwise `cnt` increments.
- **Get (opcode 4).**
  - The repeater presents the same message every beat.
  - `io_repeat = ~last`.
  - `io_out_a_mask` is forced to 1.
- **Data-carrying opcodes (0 PutFull, 1 PutPartial, 2 Arithmetic, 3 Logical).**
  - Each incoming beat is already one byte. `io_repeat = 0`.
  - Mask and data pass through unchanged.
  - Opcodes 2 and 3 with size > 0 are split like Puts and are not atomic across bytes.
- **Hint (opcode 5) and opcodes 6–7.**
  - `last` is forced to 1 and `io_repeat = 0`.
  - Passed through with the original size.
- **Output A fields.**
  - `io_out_a_valid = io_in_a_valid` and `io_in_a_ready = io_out_a_ready`.
  - `io_out_a_size = 0`, except for opcode ≥ 5, which keeps the original size.
  - `io_out_a_address = in_address | cnt`, zero-extended to 30 bits. Input addresses are size-aligned.
  - `io_out_a_source = {last, in_source}`.
- **Size table.**
  - On an A fire with `cnt == 0`, `size_tab[in_source]` is loaded with `io_in_a_size`.
- **D fold.**
  - Let `s = io_out_d_source[1:0]` and `lb = io_out_d_source[2]`.
  - Drop condition: `drop = (io_out_d_opcode == 0) & ~lb`. These are AccessAcks for non-final Put fragments.
  - Dropped beats: `io_in_d_valid = 0` and `io_out_d_ready = 1`. On the fire, `err_sticky[s]` is set if `io_out_d_error` is 1.
  - Forwarded beats: `io_in_d_valid = io_out_d_valid` and `io_out_d_ready = io_in_d_ready`. `io_in_d_source = s`, `io_in_d_size = size_tab[s]`, and `io_in_d_error = io_out_d_error | err_sticky[s]`.
  - `err_sticky[s]` is cleared on the fire of a forwarded beat with `lb = 1`.
  - AccessAckData beats, and Hint acks (opcode 2), are always forwarded.
- **Unsupported sizes.** `size > MAX_SIZE` is unsupported; the counter wraps at `MAX_SIZE` bits.

## Timing
- Zero added latency on both channels: valid, ready and bits are purely combinational from inputs and state.
- Reset values:
  - `cnt = 0`, `size_tab` all 0, `err_sticky` all 0.
  - `io_repeat = 0` while `io_in_a_valid` is low.
  - Every other output is a combinational function of inputs and this reset state.
- `io_repeat` for a Get must be valid in the same cycle as the fire. The repeater samples it together with `deq_ready & deq_valid`.
- Backpressure (`io_out_a_ready = 0`) holds `cnt`.
- `io_repeat` is not qualified by ready; the repeater gates it itself.
- A fire and a D fire to the same source in one cycle: the size-table write and the sticky update/clear are independent. The D read uses the pre-edge `size_tab`.
- A sticky set and clear on the same beat cannot occur, because a beat is either dropped or last.
- Reset asserted mid-burst: all state clears immediately. The next A beat is treated as fragment 0.

## Test plan
- **Get of 4 bytes.** Get size 2 at address 0x100, source 1, `out_a_ready = 1`.
  - A side: 4 out beats at addresses 0x100–0x103, size 0, source {0,1}×3 then {1,1}. `io_repeat` is 1,1,1,0.
  - D side: four AccessAckData beats are forwarded with size 2, source 1.
- **PutFull of 8 bytes.** PutFull size 3 at address 0x40, bytes 0x00–0x07.
  - A side: 8 single-byte puts at 0x40–0x47 with matching data. `io_repeat` stays 0.
  - D side: 7 acks are dropped (`io_out_d_ready` = 1, `io_in_d_valid` = 0) and 1 is forwarded with size 3.
- **Put error folding.** Same Put as above, with fragment 2's ack carrying error = 1.
  - The forwarded final ack has error = 1.
  - A following clean size-0 Put to the same source acks with error = 0.
- **Backpressure.** Get size 1 with `out_a_ready` low for 3 cycles on each fragment.
  - `cnt` holds during the stalls.
  - Exactly 2 fragments are issued, at addresses +0 and +1.
- **Reset and Hint.** Assert `rst_n` low after 2 of 4 Get fragments.
  - All state returns to 0.
  - A Hint size 2 afterwards passes through as a single beat with size 2 and source {1,src}.
